// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential MIPS ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_MFHI  = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MFLO  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// shift register pair, one adder/subtractor and one iteration counter.
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             isDiv_i,
    input  logic [WIDTH-1:0] opA_i,
    input  logic [WIDTH-1:0] opB_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] upper_q, upper_d;
    logic [WIDTH-1:0] lower_q, lower_d;
    logic [WIDTH-1:0] divisor_q;
    logic             isDiv_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH+1:0] addA, addB, addSum;
    logic             borrow;

    // upper/lower hold {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        addA    = isDiv_q ? {1'b0, upper_q, lower_q[WIDTH-1]} : {2'b00, upper_q};
        addB    = {2'b00, divisor_q};
        addSum  = isDiv_q ? (addA - addB) : (addA + addB);
        borrow  = addSum[WIDTH+1];
        upper_d = upper_q;
        lower_d = lower_q;
        if (isDiv_q) begin
            upper_d = borrow ? addA[WIDTH-1:0] : addSum[WIDTH-1:0];
            lower_d = {lower_q[WIDTH-2:0], ~borrow};
        end else if (lower_q[0]) begin
            {upper_d, lower_d} = {addSum[WIDTH:0], lower_q[WIDTH-1:1]};
        end else begin
            {upper_d, lower_d} = {1'b0, upper_q, lower_q[WIDTH-1:1]};
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_W'(1));
    assign hi_o   = upper_d;
    assign lo_o   = lower_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upper_q   <= '0;
            lower_q   <= '0;
            divisor_q <= '0;
            isDiv_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else if (start_i) begin
            upper_q   <= '0;
            lower_q   <= opA_i;
            divisor_q <= opB_i;
            isDiv_q   <= isDiv_i;
            busy_q    <= 1'b1;
            cnt_q     <= CNT_W'(WIDTH);
        end else if (busy_q) begin
            upper_q <= upper_d;
            lower_q <= lower_d;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered MIPS ALU with valid/ready issue, single-cycle logic/arith ops
// and iterative MULTU/DIVU writing the HI/LO pair.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, overflow_q, outValid_q, mdDone_q;

    logic             accept, isMulDivOp, mdDone;
    logic [WIDTH-1:0] mdHi, mdLo, addSum, subDiff, aluResult;
    logic             aluOverflow;

    assign isMulDivOp = (ALUControl == ALU_MULTU) || (ALUControl == ALU_DIVU);
    assign accept     = in_valid && in_ready;

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && isMulDivOp),
        .isDiv_i (ALUControl == ALU_DIVU),
        .opA_i   (input1),
        .opB_i   (input2),
        .done_o  (mdDone),
        .hi_o    (mdHi),
        .lo_o    (mdLo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && ALUControl == ALU_MULTU) begin
                    state_d = ST_MUL;
                end else if (accept && ALUControl == ALU_DIVU) begin
                    state_d = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (mdDone) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stay closed during the multi-cycle completion pulse as well
    always_comb begin
        in_ready = (state_q == ST_IDLE) && !mdDone_q;
    end

    always_comb begin
        addSum      = input1 + input2;
        subDiff     = input1 - input2;
        aluResult   = '0;
        aluOverflow = 1'b0;
        case (ALUControl)
            ALU_ADD: begin
                aluResult   = addSum;
                aluOverflow = (input1[MSB] == input2[MSB]) && (addSum[MSB] != input1[MSB]);
            end
            ALU_SUB: begin
                aluResult   = subDiff;
                aluOverflow = (input1[MSB] != input2[MSB]) && (subDiff[MSB] != input1[MSB]);
            end
            ALU_AND:  aluResult = input1 & input2;
            ALU_OR:   aluResult = input1 | input2;
            ALU_XOR:  aluResult = input1 ^ input2;
            ALU_NOR:  aluResult = ~(input1 | input2);
            ALU_SLT:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            ALU_SLTU: aluResult = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            ALU_MFHI: aluResult = hi_q;
            ALU_MFLO: aluResult = lo_q;
            default:  aluResult = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            outValid_q <= 1'b0;
            mdDone_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            outValid_q <= 1'b0;
            mdDone_q   <= 1'b0;
            if (mdDone) begin
                hi_q       <= mdHi;
                lo_q       <= mdLo;
                result_q   <= mdLo;
                zero_q     <= (mdLo == '0);
                overflow_q <= 1'b0;
                outValid_q <= 1'b1;
                mdDone_q   <= 1'b1;
            end else if (accept && !isMulDivOp) begin
                result_q   <= aluResult;
                zero_q     <= (aluResult == '0);
                overflow_q <= aluOverflow;
                outValid_q <= 1'b1;
            end
        end
    end

    assign out_valid = outValid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_MFHI  = 4'b1011;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   ALUControl = 4'b0;
    logic [W-1:0] input1 = '0;
    logic [W-1:0] input2 = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int passes = 0;

    logic [W-1:0] mHi = '0;
    logic [W-1:0] mLo = '0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .input1     (input1),
        .input2     (input2),
        .out_valid  (out_valid),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .hi         (hi),
        .lo         (lo)
    );

    // Reference for single-cycle ops: overflow means the true signed value differs from the wrapped one
    function automatic void refSingle(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] r, output logic ovf);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        r   = '0;
        ovf = 1'b0;
        case (op)
            4'b0010: begin r = a + b; s = sa + sb; ovf = (s != longint'($signed(r))); end
            4'b0110: begin r = a - b; s = sa - sb; ovf = (s != longint'($signed(r))); end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b1100: r = ~(a | b);
            4'b0111: r = (sa < sb) ? 1 : 0;
            4'b1000: r = (a < b) ? 1 : 0;
            4'b1011: r = mHi;
            4'b1101: r = mLo;
            default: r = '0;
        endcase
    endfunction

    function automatic void refMulDiv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] rHi, output logic [W-1:0] rLo);
        logic [2*W-1:0] p;
        if (op == OP_MULTU) begin
            p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            rHi = p[2*W-1:W];
            rLo = p[W-1:0];
        end else if (b == '0) begin
            rHi = a;
            rLo = '1;
        end else begin
            rHi = a % b;
            rLo = a / b;
        end
    endfunction

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid   = 1'b1;
        ALUControl = op;
        input1     = a;
        input2     = b;
        @(posedge clk);
        #1;
    endtask

    // Issue a MULTU/DIVU and wait for its pulse; optionally hold an ADD request meanwhile
    task automatic runMulDiv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit holdAdd, input logic [W-1:0] ha, input logic [W-1:0] hb,
                             output int lat, output bit readyLeak);
        drive(op, a, b);
        if (holdAdd) begin
            ALUControl = OP_ADD;
            input1     = ha;
            input2     = hb;
        end else begin
            in_valid = 1'b0;
        end
        lat       = 1;
        readyLeak = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) readyLeak = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (result !== '0) $display("[TB] FAIL reset_result: got %h expected 0", result); else passes++;
        checks++; if (zero !== 1'b1) $display("[TB] FAIL reset_zero: got %b expected 1", zero); else passes++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); else passes++;
        checks++; if (hi !== '0 || lo !== '0) $display("[TB] FAIL reset_hilo: got %h/%h expected 0/0", hi, lo); else passes++;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mHi = '0;
        mLo = '0;
    endtask

    task automatic test_add_overflow;
        logic [W-1:0] r;
        logic ovf;
        refSingle(OP_ADD, 32'h7FFF_FFFF, 32'h1, r, ovf);
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL add_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (result !== r) $display("[TB] FAIL add_result: got %h expected %h", result, r); else passes++;
        checks++; if (overflow !== ovf) $display("[TB] FAIL add_overflow: got %b expected %b", overflow, ovf); else passes++;
        checks++; if (zero !== 1'b0) $display("[TB] FAIL add_zero: got %b expected 0", zero); else passes++;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL add_pulse_width: got %b expected 0", out_valid); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [3:0]   ops [3] = '{OP_SUB, OP_SLT, OP_SLTU};
        logic [W-1:0] as  [3] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] bs  [3] = '{32'd5, 32'd1, 32'd1};
        logic [W-1:0] r;
        logic ovf;
        for (int i = 0; i < 3; i++) begin
            refSingle(ops[i], as[i], bs[i], r, ovf);
            drive(ops[i], as[i], bs[i]);
            checks++; if (out_valid !== 1'b1 || result !== r || zero !== (r == '0))
                $display("[TB] FAIL b2b_%0d: got v=%b r=%h z=%b expected v=1 r=%h z=%b", i, out_valid, result, zero, r, (r == '0));
            else passes++;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL b2b_idle: got %b expected 0", out_valid); else passes++;
    endtask

    task automatic test_multu;
        int lat;
        bit leak;
        logic [W-1:0] eHi, eLo, r;
        logic ovf;
        refMulDiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, eHi, eLo);
        runMulDiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, '0, lat, leak);
        checks++; if (lat !== W + 1) $display("[TB] FAIL mul_latency: got %0d expected %0d", lat, W + 1); else passes++;
        checks++; if (leak) $display("[TB] FAIL mul_busy_ready: got 1 expected 0"); else passes++;
        checks++; if (hi !== eHi || lo !== eLo) $display("[TB] FAIL mul_hilo: got %h/%h expected %h/%h", hi, lo, eHi, eLo); else passes++;
        checks++; if (result !== eLo) $display("[TB] FAIL mul_result: got %h expected %h", result, eLo); else passes++;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL mul_done_ready: got %b expected 0", in_ready); else passes++;
        mHi = eHi;
        mLo = eLo;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL mul_ready_back: got %b expected 1", in_ready); else passes++;
        refSingle(OP_MFHI, '0, '0, r, ovf);
        drive(OP_MFHI, '0, '0);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== r) $display("[TB] FAIL mfhi: got v=%b r=%h expected v=1 r=%h", out_valid, result, r); else passes++;
    endtask

    task automatic test_divu;
        logic [W-1:0] as [2] = '{32'd100, 32'd9};
        logic [W-1:0] bs [2] = '{32'd7, 32'd0};
        logic [W-1:0] eHi, eLo;
        int lat;
        bit leak;
        for (int i = 0; i < 2; i++) begin
            refMulDiv(OP_DIVU, as[i], bs[i], eHi, eLo);
            runMulDiv(OP_DIVU, as[i], bs[i], 1'b0, '0, '0, lat, leak);
            checks++; if (lat !== W + 1 || leak) $display("[TB] FAIL div_%0d_timing: got lat=%0d leak=%b expected lat=%0d leak=0", i, lat, leak, W + 1); else passes++;
            checks++; if (hi !== eHi || lo !== eLo) $display("[TB] FAIL div_%0d_hilo: got %h/%h expected %h/%h", i, hi, lo, eHi, eLo); else passes++;
            mHi = eHi;
            mLo = eLo;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hold_during_div;
        logic [W-1:0] a, b, ha, hb, eHi, eLo, r;
        logic ovf;
        int lat;
        bit leak;
        a  = $urandom;
        b  = 32'($urandom_range(1, 1000));
        ha = $urandom;
        hb = $urandom;
        refMulDiv(OP_DIVU, a, b, eHi, eLo);
        runMulDiv(OP_DIVU, a, b, 1'b1, ha, hb, lat, leak);
        checks++; if (lat !== W + 1 || leak) $display("[TB] FAIL hold_div_timing: got lat=%0d leak=%b expected lat=%0d leak=0", lat, leak, W + 1); else passes++;
        checks++; if (hi !== eHi || lo !== eLo) $display("[TB] FAIL hold_div_hilo: got %h/%h expected %h/%h", hi, lo, eHi, eLo); else passes++;
        mHi = eHi;
        mLo = eLo;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL hold_gap: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); else passes++;
        refSingle(OP_ADD, ha, hb, r, ovf);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== r || overflow !== ovf) $display("[TB] FAIL hold_add: got v=%b r=%h o=%b expected v=1 r=%h o=%b", out_valid, result, overflow, r, ovf); else passes++;
        checks++; if (hi !== mHi || lo !== mLo) $display("[TB] FAIL hold_hilo_kept: got %h/%h expected %h/%h", hi, lo, mHi, mLo); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul;
        bit sawValid = 1'b0;
        logic [W-1:0] r;
        logic ovf;
        drive(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5679);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        mHi = '0;
        mLo = '0;
        checks++; if (hi !== mHi || lo !== mLo) $display("[TB] FAIL midrst_hilo: got %h/%h expected 0/0", hi, lo); else passes++;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1)
            $display("[TB] FAIL midrst_outputs: got rdy=%b v=%b r=%h z=%b expected 1/0/0/1", in_ready, out_valid, result, zero);
        else passes++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        checks++; if (sawValid) $display("[TB] FAIL midrst_no_pulse: got 1 expected 0"); else passes++;
        refSingle(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, r, ovf);
        drive(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== r) $display("[TB] FAIL midrst_and: got v=%b r=%h expected v=1 r=%h", out_valid, result, r); else passes++;
    endtask

    task automatic test_random;
        logic [3:0]   op;
        logic [W-1:0] a, b, r, eHi, eLo;
        logic ovf;
        int lat;
        bit leak;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : a;
            if (op == OP_DIVU && $urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            if (op == OP_MULTU || op == OP_DIVU) begin
                refMulDiv(op, a, b, eHi, eLo);
                runMulDiv(op, a, b, 1'b0, '0, '0, lat, leak);
                checks++; if (lat !== W + 1 || leak || result !== eLo || hi !== eHi || lo !== eLo)
                    $display("[TB] FAIL rand_%0d_md op=%h: got lat=%0d leak=%b r=%h hi=%h lo=%h expected lat=%0d r=%h hi=%h lo=%h",
                             i, op, lat, leak, result, hi, lo, W + 1, eLo, eHi, eLo);
                else passes++;
                mHi = eHi;
                mLo = eLo;
                @(posedge clk);
                #1;
            end else begin
                refSingle(op, a, b, r, ovf);
                drive(op, a, b);
                checks++; if (out_valid !== 1'b1 || result !== r || zero !== (r == '0) || overflow !== ovf || hi !== mHi || lo !== mLo)
                    $display("[TB] FAIL rand_%0d op=%h a=%h b=%h: got v=%b r=%h z=%b o=%b hi=%h lo=%h expected r=%h z=%b o=%b hi=%h lo=%h",
                             i, op, a, b, out_valid, result, zero, overflow, hi, lo, r, (r == '0), ovf, mHi, mLo);
                else passes++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_multu();
        test_divu();
        test_hold_during_div();
        test_reset_mid_mul();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle MIPS ALU.
- Keeps the existing ALUControl encodings for ADD, SUB, AND and OR, and makes SLT signed.
- Adds SLTU, XOR, NOR, signed-overflow detection, and iterative unsigned multiply/divide into HI/LO registers, with MFHI/MFLO readout.
- Sits in the multi-cycle datapath between the register-file read stage and write-back, under a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits, >= 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- ALUControl  input  4  operation select.
- input1  input  WIDTH  operand A.
- input2  input  WIDTH  operand B.
- out_valid  output  1  one-cycle pulse; result, zero and overflow are valid.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow; ADD/SUB only.
- hi  output  WIDTH  HI register: product high half / remainder.
- lo  output  WIDTH  LO register: product low half / quotient.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - result=0, zero=1, overflow=0, hi=0, lo=0, counter=0.
- Accept: a request is taken when in_valid && in_ready. Operands and op are captured in that cycle.
- Encodings:
  - 0010 ADD, 0110 SUB, 0000 AND, 0001 OR.
  - 0111 SLT (signed), 1000 SLTU, 0011 XOR, 1100 NOR.
  - 1001 MULTU, 1010 DIVU, 1011 MFHI, 1101 MFLO.
  - Any other code: result=0.
- Single-cycle ops (all except MULTU/DIVU):
  - result, zero and overflow are registered; out_valid=1 on the cycle after accept.
  - State stays IDLE and in_ready stays 1, so back-to-back issue gives one result per cycle.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ADD overflow = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB overflow = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - overflow=0 for all other ops.
  - SLT/SLTU give result = {WIDTH-1 zeros, lt}.
  - MFHI returns hi and MFLO returns lo, as registered before the accept cycle.
- MULTU, shift-add:
  - IDLE -> MUL, in_ready=0.
  - Exactly WIDTH iterations, one per clock.
  - Then {hi,lo} = full 2*WIDTH-bit product, result=lo, out_valid pulse, return to IDLE.
  - Latency from accept to out_valid = WIDTH+1 cycles.
- DIVU, restoring:
  - IDLE -> DIV, in_ready=0.
  - WIDTH iterations, then lo=quotient, hi=remainder, result=lo, out_valid pulse, return to IDLE.
  - Latency = WIDTH+1 cycles.
  - Divide by zero is not trapped: lo = all ones, hi = input1, same latency.
- hi/lo are modified only on MULTU/DIVU completion. Single-cycle ops never touch them.
- in_valid while busy: ignored; in_ready=0 and the request is not queued. The upstream must hold it.
- in_valid on the completion cycle: not accepted. in_ready returns to 1 on the cycle after out_valid.
- out_valid has no backpressure; the consumer must take the result on the pulse. result holds its value until the next completion.
- Reset mid-MUL/DIV: the operation is aborted, hi/lo clear to 0, and no out_valid is produced.
- States: IDLE, MUL, DIV (2-bit encoding). Counter loads WIDTH on accept and decrements each iteration; completion occurs when the counter reaches 1 during an iteration.

Decomposition:
- Package alu_pkg holds:
  - 4-bit ALUControl localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_NOR, ALU_MULTU, ALU_DIVU, ALU_MFHI, ALU_MFLO).
  - State encoding constants.
- One sub-module, alu_muldiv_iter, holds the shared shift register, adder/subtractor and counter for MULTU/DIVU. It has a start/done interface and is instantiated once.
- The combinational single-cycle op decode stays in alu_seq.

Test Plan:
- Reset then ADD 0x7FFFFFFF+1 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0.
- Back-to-back SUB 5-5, SLT 0xFFFFFFFF<1, SLTU 0xFFFFFFFF<1 -> three consecutive pulses: result=0 with zero=1, then result=1, then result=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> out_valid exactly 33 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001, in_ready=0 throughout. MFHI issued next returns 0xFFFFFFFE.
- DIVU 100/7 -> lo=14, hi=2 after 33 cycles. DIVU 9/0 -> lo=0xFFFFFFFF, hi=9.
- in_valid held with ADD during DIVU -> not accepted until in_ready rises; ADD result appears the cycle after acceptance; hi/lo unchanged by the ADD.
- rst_n pulsed low at iteration 10 of MULTU -> outputs immediately at reset values, no out_valid. A fresh AND 0xF0F0&0x0FF0 afterward returns 0x00F0.
